// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with saturating direction counters.
// Lookup is combinational from the registered table; updates and flushes land at the rising edge.
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 2,
  parameter int PC_W    = 32,
  parameter int PERF_W  = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [PC_W-1:0]   lookup_pc,
  output logic              pred_taken,
  output logic [PC_W-1:0]   pred_target,
  input  logic              upd_en,
  input  logic [PC_W-1:0]   upd_pc,
  input  logic              upd_taken,
  input  logic [PC_W-1:0]   upd_target,
  input  logic              upd_mispred,
  input  logic              stall,
  input  logic              flush_all,
  output logic [PERF_W-1:0] branch_cnt,
  output logic [PERF_W-1:0] mispred_cnt
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;
  localparam logic [CNT_W-1:0]  CTR_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CTR_WT   = CNT_W'(1) << (CNT_W - 1);
  localparam logic [CNT_W-1:0]  CTR_WNT  = CTR_WT - CNT_W'(1);
  localparam logic [PERF_W-1:0] PERF_MAX = {PERF_W{1'b1}};

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [PC_W-1:0]    target_q [ENTRIES];
  logic [CNT_W-1:0]   ctr_q    [ENTRIES];

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             lk_hit, up_hit, honored;

  assign lk_idx = lookup_pc[IDX_W+1:2];
  assign lk_tag = lookup_pc[PC_W-1:IDX_W+2];
  assign up_idx = upd_pc[IDX_W+1:2];
  assign up_tag = upd_pc[PC_W-1:IDX_W+2];

  always_comb begin
    lk_hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    pred_taken  = lk_hit && ctr_q[lk_idx][CNT_W-1];
    pred_target = pred_taken ? target_q[lk_idx] : lookup_pc + PC_W'(4);
  end

  // upd_en acts as a valid with no ready: the update is consumed or dropped in the
  // cycle it is presented; stall or flush_all drop it and EX re-presents it later.
  assign honored = upd_en && !stall && !flush_all;
  assign up_hit  = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_WNT;
      end
    end else if (flush_all) begin
      valid_q <= '0;
    end else if (honored) begin
      if (up_hit) begin
        if (upd_taken) begin
          target_q[up_idx] <= upd_target;
          if (ctr_q[up_idx] != CTR_MAX) ctr_q[up_idx] <= ctr_q[up_idx] + CNT_W'(1);
        end else if (ctr_q[up_idx] != '0) begin
          ctr_q[up_idx] <= ctr_q[up_idx] - CNT_W'(1);
        end
      end else if (upd_taken) begin
        // Allocate on taken miss only; not-taken branches behave like the fall-through default.
        valid_q[up_idx]  <= 1'b1;
        tag_q[up_idx]    <= up_tag;
        target_q[up_idx] <= upd_target;
        ctr_q[up_idx]    <= CTR_WT;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else if (honored) begin
      if (branch_cnt != PERF_MAX) branch_cnt <= branch_cnt + PERF_W'(1);
      if (upd_mispred && (mispred_cnt != PERF_MAX)) mispred_cnt <= mispred_cnt + PERF_W'(1);
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: directed scenarios then random traffic,
// checked against an index/tag/counter model of the prediction rules.
module tb_branch_predictor;
  localparam int EW = 1 + 32 + 16 + 16 + 4 + 4;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic [31:0] lookup_pc = '0;
  logic        upd_en = 1'b0, upd_taken = 1'b0, upd_mispred = 1'b0;
  logic [31:0] upd_pc = '0, upd_target = '0;
  logic        stall = 1'b0, flush_all = 1'b0;
  logic        pred_taken, pred_taken_p4;
  logic [31:0] pred_target, pred_target_p4;
  logic [15:0] branch_cnt, mispred_cnt;
  logic [3:0]  branch_cnt_p4, mispred_cnt_p4;

  branch_predictor u_dut (
    .CLK(CLK), .nRST(nRST), .lookup_pc(lookup_pc), .pred_taken(pred_taken),
    .pred_target(pred_target), .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_mispred(upd_mispred), .stall(stall), .flush_all(flush_all),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  branch_predictor #(.PERF_W(4)) u_dut_p4 (
    .CLK(CLK), .nRST(nRST), .lookup_pc(lookup_pc), .pred_taken(pred_taken_p4),
    .pred_target(pred_target_p4), .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_mispred(upd_mispred), .stall(stall), .flush_all(flush_all),
    .branch_cnt(branch_cnt_p4), .mispred_cnt(mispred_cnt_p4)
  );

  // clock/reset
  always #5 CLK = ~CLK;

  // reference model
  bit          m_valid [16];
  int unsigned m_tag   [16];
  logic [31:0] m_target[16];
  int          m_ctr   [16];
  int          m_bcnt, m_mcnt;

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_target[i] = '0; m_ctr[i] = 1;
    end
    m_bcnt = 0; m_mcnt = 0;
  endfunction

  function automatic logic [EW-1:0] model_expect(input logic [31:0] pc);
    int unsigned idx = (pc / 4) % 16;
    bit hit = m_valid[idx] && (m_tag[idx] == pc / 64);
    bit tk  = hit && (m_ctr[idx] >= 2);
    logic [31:0] tgt = tk ? m_target[idx] : pc + 32'd4;
    int b4 = (m_bcnt > 15) ? 15 : m_bcnt;
    int mc4 = (m_mcnt > 15) ? 15 : m_mcnt;
    int b16 = (m_bcnt > 65535) ? 65535 : m_bcnt;
    int mc16 = (m_mcnt > 65535) ? 65535 : m_mcnt;
    return {tk, tgt, 16'(b16), 16'(mc16), 4'(b4), 4'(mc4)};
  endfunction

  function automatic void model_edge(input bit en, input logic [31:0] pc, input bit tk,
                                     input logic [31:0] tgt, input bit mp, input bit st, input bit fl);
    int unsigned idx = (pc / 4) % 16;
    bit hit = m_valid[idx] && (m_tag[idx] == pc / 64);
    if (fl) begin
      for (int i = 0; i < 16; i++) m_valid[i] = 0;
      return;
    end
    if (!en || st) return;
    m_bcnt++;
    if (mp) m_mcnt++;
    if (hit && tk) begin
      m_target[idx] = tgt;
      if (m_ctr[idx] < 3) m_ctr[idx]++;
    end else if (hit) begin
      if (m_ctr[idx] > 0) m_ctr[idx]--;
    end else if (tk) begin
      m_valid[idx] = 1; m_tag[idx] = pc / 64; m_target[idx] = tgt; m_ctr[idx] = 2;
    end
  endfunction

  // scoreboard
  logic [EW-1:0] exp_q[$];
  logic          chk_valid = 1'b0;
  int            total = 0, bad = 0;

  always @(negedge CLK) begin
    if (chk_valid) begin
      logic [EW-1:0] e, a;
      a = {pred_taken, pred_target, branch_cnt, mispred_cnt, branch_cnt_p4, mispred_cnt_p4};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL scoreboard_underflow actual=%h", a);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          bad++;
          $display("FAIL lookup pc=%h actual{tk,tgt,bc,mc,bc4,mc4}=%h required=%h",
                   lookup_pc, a, e);
        end
        if (pred_taken_p4 !== e[EW-1] || pred_target_p4 !== e[EW-2 -: 32]) begin
          bad++;
          $display("FAIL lookup_p4 pc=%h actual=%b/%h required=%b/%h", lookup_pc,
                   pred_taken_p4, pred_target_p4, e[EW-1], e[EW-2 -: 32]);
        end
      end
    end
  end

  // driver: one cycle of lookup plus optional update
  task automatic cycle(input logic [31:0] lpc, input bit en = 0, input logic [31:0] pc = '0,
                       input bit tk = 0, input logic [31:0] tgt = '0, input bit mp = 0,
                       input bit st = 0, input bit fl = 0);
    lookup_pc = lpc; upd_en = en; upd_pc = pc; upd_taken = tk; upd_target = tgt;
    upd_mispred = mp; stall = st; flush_all = fl;
    exp_q.push_back(model_expect(lpc));
    chk_valid = 1'b1;
    @(posedge CLK); #1;
    model_edge(en, pc, tk, tgt, mp, st, fl);
    chk_valid = 1'b0;
  endtask

  task automatic upd(input logic [31:0] pc, input bit tk, input logic [31:0] tgt, input bit mp = 0);
    cycle(pc, 1, pc, tk, tgt, mp);
  endtask

  initial begin
    model_reset();
    @(posedge CLK); #1;
    lookup_pc = 32'h40;
    exp_q.push_back(model_expect(32'h40));
    chk_valid = 1'b1;
    @(posedge CLK); #1;
    chk_valid = 1'b0;
    nRST = 1'b1;

    // allocate and predict
    upd(32'h40, 1, 32'h100, 1);
    cycle(32'h40);
    // counter walk
    upd(32'h40, 0, 32'h0); upd(32'h40, 0, 32'h0);
    for (int i = 0; i < 4; i++) upd(32'h40, 1, 32'h100);
    upd(32'h40, 0, 32'h0);
    cycle(32'h40);
    // aliasing on index 0
    cycle(32'h80);
    upd(32'h80, 1, 32'h200);
    cycle(32'h80); cycle(32'h40);
    // stall, flush with concurrent update, no allocation on not-taken
    cycle(32'h80, 1, 32'h80, 0, 32'h0, 1, 1, 0);
    cycle(32'h80);
    upd(32'h2C, 1, 32'h300);
    cycle(32'h80, 1, 32'h1C, 1, 32'h400, 1, 0, 1);
    cycle(32'h80); cycle(32'h2C); cycle(32'h1C);
    upd(32'h44, 0, 32'h0);
    cycle(32'h44);
    cycle(32'hFFFF_FFFC);

    // random traffic over a small aliasing-prone PC set
    for (int n = 0; n < 300; n++) begin
      logic [31:0] lp, up;
      lp = {26'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      up = {26'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      cycle(lp, $urandom_range(0, 3) != 0, up, $urandom_range(0, 1) == 1, $urandom,
            $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0, $urandom_range(0, 31) == 0);
    end

    // saturate the narrow counters, then reset mid-cycle
    for (int i = 0; i < 20; i++) upd(32'h40, 1, 32'h100, 1);
    cycle(32'h40);
    #1;
    nRST = 1'b0;
    model_reset();
    lookup_pc = 32'h40;
    exp_q.push_back(model_expect(32'h40));
    chk_valid = 1'b1;
    @(posedge CLK); #1;
    chk_valid = 1'b0;
    nRST = 1'b1;
    cycle(32'h40);

    repeat (2) @(posedge CLK);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
